// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter: FSM state encoding and word alignment.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIfAcc,
    StDRd,
    StDWr
  } arb_state_e;

  // Number of byte-offset bits cleared to form a word address
  localparam int unsigned ByteOffW = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (fetch and load/store), memory and stall signals around the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          d_misalign;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          pc_stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid, d_misalign, mem_addr, mem_wdata, mem_we,
           pc_stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid, d_misalign, mem_addr, mem_wdata, mem_we,
           pc_stall
  );

endinterface

// File: rtl/mem_lat_counter.sv
// Memory latency down-counter: loaded with MEM_LAT at grant, done once it has run down to zero.
module mem_lat_counter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic done
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CntW'(MEM_LAT);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one access at a time,
// with data priority bounded by a fetch starvation counter.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  arb_state_e         state_q, state_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic               starved, grant_if, grant_d, lat_done, if_done, d_rd_done;

  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
  logic          mem_we_q, if_valid_q, d_valid_q, d_misalign_q, misalign_q;
  logic          unused_if_lo;

  assign unused_if_lo = ^bus.if_addr[ByteOffW-1:0];

  assign starved  = (starve_q == StarveW'(STARVE_MAX));
  assign grant_if = (state_q == StIdle) && bus.if_req && (!bus.d_req || starved);
  assign grant_d  = (state_q == StIdle) && bus.d_req && !grant_if;

  assign if_done   = (state_q == StIfAcc) && lat_done;
  assign d_rd_done = (state_q == StDRd) && lat_done;

  mem_lat_counter #(
    .MEM_LAT(MEM_LAT)
  ) u_lat_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (grant_if || (grant_d && !bus.d_we)),
    .done   (lat_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_if) begin
          state_d = StIfAcc;
        end else if (grant_d) begin
          state_d = bus.d_we ? StDWr : StDRd;
        end
      end
      StIfAcc, StDRd: if (lat_done) state_d = StIdle;
      StDWr:          state_d = StIdle;
      default:        state_d = StIdle;
    endcase
  end

  // A data grant only reaches the increment when if_req is high
  always_comb begin
    starve_d = starve_q;
    if (state_q == StIdle) begin
      if (grant_if || !bus.if_req) begin
        starve_d = '0;
      end else if (grant_d && !starved) begin
        starve_d = starve_q + StarveW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      misalign_q   <= 1'b0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      d_misalign_q <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      mem_we_q     <= grant_d && bus.d_we;
      if_valid_q   <= if_done;
      d_valid_q    <= d_rd_done || (state_q == StDWr);
      d_misalign_q <= (d_rd_done || (state_q == StDWr)) && misalign_q;
      if (grant_if) begin
        mem_addr_q  <= {bus.if_addr[AW-1:ByteOffW], {ByteOffW{1'b0}}};
        mem_wdata_q <= '0;
      end else if (grant_d) begin
        mem_addr_q  <= {bus.d_addr[AW-1:ByteOffW], {ByteOffW{1'b0}}};
        mem_wdata_q <= bus.d_wdata;
        misalign_q  <= (bus.d_addr[ByteOffW-1:0] != '0);
      end
      if (if_done)   if_rdata_q <= bus.mem_rdata;
      if (d_rd_done) d_rdata_q  <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.if_valid   = if_valid_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_valid    = d_valid_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.d_misalign = d_misalign_q;
  assign bus.pc_stall   = (bus.if_req && !if_valid_q) || (bus.d_req && !d_valid_q);

endmodule
